// File: rtl/adc_ovfl_window_mon.sv
// adc_ovfl_window_mon
// Multi-channel windowed ADC-overflow monitor. Each channel counts
// overflow-flagged samples over a window of 2^win samples. A channel raises a
// one-cycle event when its window count reaches the threshold. A sticky flag
// per channel and the last-window counts are kept for status readback.
//
// Optional feature: define ADC_OVFL_PEAK_EN to add per-channel peak window
// count registers, read through rd_peak. Without the macro, rd_peak is tied
// to 0.

module adc_ovfl_window_mon #(
  parameter int NCH          = 2,
  parameter int MAX_WIN_BITS = 16,
  parameter int SEL_BITS     = 3,
  localparam int CNT_BITS    = MAX_WIN_BITS + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_en,
  input  logic [NCH-1:0]      ovfl_in,
  input  logic                cfg_wr,
  input  logic [4:0]          win_log2,
  input  logic [CNT_BITS-1:0] thresh,
  input  logic                sticky_clr,
  input  logic [SEL_BITS-1:0] rd_sel,
  output logic [NCH-1:0]      ovfl_pulse,
  output logic [NCH-1:0]      ovfl_sticky,
  output logic                win_done,
  output logic [CNT_BITS-1:0] rd_cnt,
  output logic [CNT_BITS-1:0] rd_peak
);

  // Active and pending configuration
  logic [4:0]          act_win;
  logic [CNT_BITS-1:0] act_thresh;
  logic [4:0]          pend_win;
  logic [CNT_BITS-1:0] pend_thresh;
  logic                pend_valid;
  logic [4:0]          wr_win;

  // Window and channel state
  logic [MAX_WIN_BITS-1:0] ctr;
  logic [MAX_WIN_BITS-1:0] win_mask;
  logic                    close;
  logic                    apply_cfg;
  logic [CNT_BITS-1:0]     cnt       [NCH];
  logic [CNT_BITS-1:0]     final_cnt [NCH];
  logic [CNT_BITS-1:0]     last_cnt  [NCH];

  // Clamp the requested window length into 1..MAX_WIN_BITS
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    wr_win = win_log2;
    if (win_log2 == 5'd0) begin
      wr_win = 5'd1;
    end else if (win_log2 > 5'(MAX_WIN_BITS)) begin
      wr_win = 5'(MAX_WIN_BITS);
    end
  end

  // The window closes on the sample where ctr reaches 2^win-1.
  // Pending config is swapped in only between windows.
  assign win_mask  = ~({MAX_WIN_BITS{1'b1}} << act_win);
  assign close     = sample_en && (ctr == win_mask);
  assign apply_cfg = pend_valid && (close || (ctr == '0));

  // The closing sample still belongs to the closing window
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      final_cnt[ch] = cnt[ch] + CNT_BITS'(ovfl_in[ch]);
    end
  end

  // Configuration capture: last write wins; activation waits for a window boundary
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      act_win     <= 5'(MAX_WIN_BITS);
      act_thresh  <= CNT_BITS'(1);
      pend_win    <= '0;
      pend_thresh <= '0;
      pend_valid  <= 1'b0;
    end else begin
      if (cfg_wr) begin
        pend_win    <= wr_win;
        pend_thresh <= thresh;
        pend_valid  <= 1'b1;
      end else if (apply_cfg) begin
        pend_valid  <= 1'b0;
      end
      if (apply_cfg) begin
        act_win    <= pend_win;
        act_thresh <= pend_thresh;
      end
    end
  end

  // Sample counter and window-close pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr      <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= close;
      if (close) begin
        ctr <= '0;
      end else if (sample_en) begin
        ctr <= ctr + 1'b1;
      end
    end
  end

  // Per-channel counters, last-window counts and threshold events
  always_ff @(posedge clk) begin
    // NOTE: these arrays are small flop banks rather than RAM, so they are
    // reset along with everything else; a mid-window reset must discard
    // partial counts.
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        cnt[ch]      <= '0;
        last_cnt[ch] <= '0;
      end
      ovfl_pulse <= '0;
    end else begin
      ovfl_pulse <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        if (close) begin
          last_cnt[ch]   <= final_cnt[ch];
          ovfl_pulse[ch] <= (act_thresh != '0) && (final_cnt[ch] >= act_thresh);
          cnt[ch]        <= '0;
        end else if (sample_en) begin
          cnt[ch] <= final_cnt[ch];
        end
      end
    end
  end

  // Sticky flags: a new pulse overrides a coincident clear so no event is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      ovfl_sticky <= '0;
    end else begin
      ovfl_sticky <= (ovfl_sticky & ~{NCH{sticky_clr}}) | ovfl_pulse;
    end
  end

`ifdef ADC_OVFL_PEAK_EN
  logic [CNT_BITS-1:0] peak [NCH];

  // Peak window count per channel; a clear coincident with a close restarts from that window
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        peak[ch] <= '0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (close) begin
          if (sticky_clr || (final_cnt[ch] > peak[ch])) begin
            peak[ch] <= final_cnt[ch];
          end
        end else if (sticky_clr) begin
          peak[ch] <= '0;
        end
      end
    end
  end

  // Readback mux; out-of-range selects read 0
  always_comb begin
    rd_cnt  = '0;
    rd_peak = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (int'(rd_sel) == ch) begin
        rd_cnt  = last_cnt[ch];
        rd_peak = peak[ch];
      end
    end
  end
`else
  // Readback mux; out-of-range selects read 0
  always_comb begin
    rd_cnt  = '0;
    rd_peak = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (int'(rd_sel) == ch) begin
        rd_cnt = last_cnt[ch];
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_ovfl_window_mon.sv
// tb_adc_ovfl_window_mon
// Directed self-checking bench for adc_ovfl_window_mon. Expected values are
// hand-computed. The peak checks follow ADC_OVFL_PEAK_EN.

module tb_adc_ovfl_window_mon;

  localparam int NCH = 2;
  localparam int MWB = 16;
  localparam int SB  = 3;
  localparam int CB  = MWB + 1;

  logic          clk;
  logic          rst;
  logic          sample_en;
  logic [NCH-1:0] ovfl_in;
  logic          cfg_wr;
  logic [4:0]    win_log2;
  logic [CB-1:0] thresh;
  logic          sticky_clr;
  logic [SB-1:0] rd_sel;
  logic [NCH-1:0] ovfl_pulse;
  logic [NCH-1:0] ovfl_sticky;
  logic          win_done;
  logic [CB-1:0] rd_cnt;
  logic [CB-1:0] rd_peak;

  int checks = 0;
  int errors = 0;

  adc_ovfl_window_mon #(
    .NCH(NCH),
    .MAX_WIN_BITS(MWB),
    .SEL_BITS(SB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_en(sample_en),
    .ovfl_in(ovfl_in),
    .cfg_wr(cfg_wr),
    .win_log2(win_log2),
    .thresh(thresh),
    .sticky_clr(sticky_clr),
    .rd_sel(rd_sel),
    .ovfl_pulse(ovfl_pulse),
    .ovfl_sticky(ovfl_sticky),
    .win_done(win_done),
    .rd_cnt(rd_cnt),
    .rd_peak(rd_peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling happens 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Write config, then leave one idle cycle for it to take effect if ctr == 0
  task automatic cfg(input int w, input int t);
    cfg_wr   = 1'b1;
    win_log2 = 5'(w);
    thresh   = CB'(t);
    tick();
    cfg_wr = 1'b0;
    tick();
  endtask

  // n samples; ch0 overflows on the first k0, ch1 on the first k1
  task automatic run_window(input int n, input int k0, input int k1);
    for (int i = 0; i < n; i++) begin
      sample_en  = 1'b1;
      ovfl_in[0] = (i < k0);
      ovfl_in[1] = (i < k1);
      tick();
    end
    sample_en = 1'b0;
    ovfl_in   = '0;
  endtask

  task automatic pulse_clr();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    sample_en  = 1'b0;
    ovfl_in    = '0;
    cfg_wr     = 1'b0;
    win_log2   = '0;
    thresh     = '0;
    sticky_clr = 1'b0;
    rd_sel     = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_pulse", 32'(ovfl_pulse), 0);
    check("rst_sticky", 32'(ovfl_sticky), 0);
    check("rst_win_done", 32'(win_done), 0);
    check("rst_rd_cnt", 32'(rd_cnt), 0);
    check("rst_rd_peak", 32'(rd_peak), 0);

    // T1: win=4, thresh=3, ch0 overflow on samples 0, 5, 15
    cfg(4, 3);
    for (int i = 0; i < 16; i++) begin
      sample_en = 1'b1;
      ovfl_in   = {1'b0, (i == 0 || i == 5 || i == 15)};
      tick();
      if (i == 14) check("t1_no_early_done", 32'(win_done), 0);
    end
    sample_en = 1'b0;
    ovfl_in   = '0;
    check("t1_win_done", 32'(win_done), 1);
    check("t1_pulse", 32'(ovfl_pulse), 32'b01);
    check("t1_rd_cnt0", 32'(rd_cnt), 3);
    check("t1_sticky_not_yet", 32'(ovfl_sticky), 0);
    rd_sel = 3'd1;
    #1;
    check("t1_rd_cnt1", 32'(rd_cnt), 0);
    rd_sel = 3'd5;
    #1;
    check("t1_rd_sel_oob", 32'(rd_cnt), 0);
    rd_sel = 3'd0;
    tick();
    check("t1_done_one_cycle", 32'(win_done), 0);
    check("t1_pulse_one_cycle", 32'(ovfl_pulse), 0);
    check("t1_sticky", 32'(ovfl_sticky), 32'b01);

    // T2: count below threshold, then threshold 0 disables events
    cfg(4, 4);
    run_window(16, 3, 0);
    check("t2_done", 32'(win_done), 1);
    check("t2_no_pulse", 32'(ovfl_pulse), 0);
    check("t2_rd_cnt", 32'(rd_cnt), 3);
    cfg(4, 0);
    run_window(16, 16, 16);
    check("t2_thr0_done", 32'(win_done), 1);
    check("t2_thr0_no_pulse", 32'(ovfl_pulse), 0);
    check("t2_thr0_rd_cnt", 32'(rd_cnt), 16);

    // T4: clear coincident with a pulse keeps the flag; a lone clear drops it
    cfg(4, 1);
    run_window(16, 2, 0);
    check("t4_pulse", 32'(ovfl_pulse), 32'b01);
    pulse_clr();
    check("t4_set_wins", 32'(ovfl_sticky), 32'b01);
    pulse_clr();
    check("t4_lone_clr", 32'(ovfl_sticky), 0);

    // T3: reconfigure mid-window; the new length applies from the next window
    cfg(4, 1);
    run_window(7, 0, 0);
    cfg(2, 1);
    run_window(8, 0, 0);
    check("t3_no_done_at_15", 32'(win_done), 0);
    run_window(1, 1, 0);
    check("t3_done_at_16", 32'(win_done), 1);
    check("t3_rd_cnt", 32'(rd_cnt), 1);
    run_window(3, 0, 0);
    check("t3_win4_no_done", 32'(win_done), 0);
    run_window(1, 1, 0);
    check("t3_win4_done", 32'(win_done), 1);

    // win_log2 = 0 behaves as a 2-sample window
    cfg(0, 1);
    run_window(1, 0, 0);
    check("t3_w0_no_done", 32'(win_done), 0);
    run_window(1, 1, 1);
    check("t3_w0_done", 32'(win_done), 1);
    check("t3_w0_pulse", 32'(ovfl_pulse), 32'b11);
    check("t3_w0_rd_cnt", 32'(rd_cnt), 1);

    // win_log2 = 31 clamps to a 2^16 window
    cfg(31, 0);
    for (int i = 0; i < 65536; i++) begin
      sample_en = 1'b1;
      ovfl_in   = 2'b11;
      tick();
      if (i == 65534) check("t3_clamp_no_early", 32'(win_done), 0);
    end
    sample_en = 1'b0;
    ovfl_in   = '0;
    check("t3_clamp_done", 32'(win_done), 1);
    check("t3_clamp_rd_cnt0", 32'(rd_cnt), 65536);
    check("t3_clamp_no_pulse", 32'(ovfl_pulse), 0);
    rd_sel = 3'd1;
    #1;
    check("t3_clamp_rd_cnt1", 32'(rd_cnt), 65536);
    rd_sel = 3'd0;
    check("t3_sticky_before_rst", 32'(ovfl_sticky), 32'b11);

    // T5: reset mid-window discards the partial window and restores defaults
    cfg(4, 1);
    run_window(10, 10, 0);
    do_reset();
    check("t5_no_done", 32'(win_done), 0);
    check("t5_no_pulse", 32'(ovfl_pulse), 0);
    check("t5_rd_cnt", 32'(rd_cnt), 0);
    check("t5_sticky", 32'(ovfl_sticky), 0);
    run_window(16, 16, 0);
    check("t5_default_win_open", 32'(win_done), 0);
    check("t5_default_no_pulse", 32'(ovfl_pulse), 0);
    do_reset();
    cfg(4, 1);
    run_window(16, 1, 0);
    check("t5_fresh_done", 32'(win_done), 1);
    check("t5_fresh_rd_cnt", 32'(rd_cnt), 1);
    check("t5_fresh_pulse", 32'(ovfl_pulse), 32'b01);

`ifdef ADC_OVFL_PEAK_EN
    // T6: peak tracking across windows, cleared by sticky_clr
    pulse_clr();
    cfg(4, 0);
    run_window(16, 5, 0);
    check("t6_peak_5", 32'(rd_peak), 5);
    run_window(16, 9, 0);
    run_window(16, 2, 0);
    check("t6_rd_cnt_2", 32'(rd_cnt), 2);
    check("t6_peak_9", 32'(rd_peak), 9);
    pulse_clr();
    check("t6_peak_clr", 32'(rd_peak), 0);
    run_window(16, 4, 0);
    check("t6_peak_4", 32'(rd_peak), 4);
`else
    // T6: without the peak feature rd_peak stays 0
    cfg(4, 0);
    run_window(16, 5, 0);
    check("t6_rd_cnt_5", 32'(rd_cnt), 5);
    check("t6_peak_tied0", 32'(rd_peak), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
